alu_issue_sequencer: RTL
========================

# alu_issue_sequencer

Request/response front end that sits directly upstream of the SimpleALU. It accepts one operation at a time over a valid/ready handshake and drives the ALU's Instruction/InputA/InputB. It waits the op-dependent number of cycles, or for the divider's Ready on DIV, then captures ResultA/ResultB and presents them downstream with status flags. It also handles divide-by-zero, unknown opcodes and divider timeouts, so the ALU never sees an illegal request.

## Interface

Parameters:
- INPUT_BIT_WIDTH, 8: operand/result width W (must match the ALU).
- INSTR_BIT_WIDTH, 5: opcode width (must match the ALU).
- ADDSUB_LATENCY, 2: EXEC cycles before capture for ADD/SUB (≥1).
- LOGIC_LATENCY, 1: EXEC cycles before capture for MUL/SHL/SHR/ROL/ROR/AND/OR/XOR/NAND/XNOR/GTH/EQU (≥1).
- DIV_MIN_CYCLES, 2: leading EXEC cycles of a DIV during which AluReady is ignored (masks a stale Ready).
- DIV_TIMEOUT, 48: maximum EXEC cycles for DIV before error (> DIV_MIN_CYCLES).
- Opcodes are identical to the ALU's: NOP 0x00, ADD 0x01, SUB 0x02, MUL 0x03, DIV 0x04, SHL 0x05, SHR 0x06, ROL 0x07, ROR 0x08, AND 0x09, XOR 0x0B, OR 0x0D, NAND 0x0E, XNOR 0x0F, GTH 0x10, EQU 0x11.

Ports:
- Clk, in, 1: single clock, rising edge.
- ResetN, in, 1: synchronous, active-low reset.
- ReqValid, in, 1: request present.
- ReqReady, out, 1: request accepted this cycle if ReqValid.
- ReqInstr, in, INSTR_BIT_WIDTH: opcode.
- ReqA, in, W: operand A.
- ReqB, in, W: operand B.
- AluInstruction, out, INSTR_BIT_WIDTH: to ALU Instruction.
- AluInputA, out, W: to ALU InputA.
- AluInputB, out, W: to ALU InputB.
- AluResultA, in, W: from ALU ResultA.
- AluResultB, in, W: from ALU ResultB.
- AluReady, in, 1: from ALU Ready (divider done).
- RespValid, out, 1: response present.
- RespReady, in, 1: downstream accepts response.
- RespA, out, W: captured result A.
- RespB, out, W: captured result B.
- RespZero, out, 1: RespA == 0.
- RespError, out, 1: div-by-zero, unknown opcode or timeout.
- Busy, out, 1: state ≠ IDLE.

## Operation

- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - ReqReady=1; ALU outputs driven NOP/0/0.
  - On ReqValid&ReqReady: latch opcode and operands.
  - Legal non-NOP, non-div-by-zero op: drive the ALU outputs from the latched values, clear the cycle counter, go to EXEC.
  - NOP: RespA=RespB=0, RespError=0, go straight to DONE.
  - DIV with ReqB==0: no ALU issue. RespA={W{1}}, RespB=ReqA, RespError=1, go to DONE.
  - Unknown opcode: no ALU issue. RespA=RespB=0, RespError=1, go to DONE.
- EXEC:
  - ALU outputs held stable; the counter increments each cycle, saturating at DIV_TIMEOUT.
  - ADD/SUB: capture AluResultA/B at the end of EXEC cycle ADDSUB_LATENCY.
  - Logic group: capture at the end of EXEC cycle LOGIC_LATENCY.
  - DIV: capture on the first EXEC cycle with counter ≥ DIV_MIN_CYCLES and AluReady=1. If DIV_TIMEOUT cycles elapse without that, set RespError=1, set RespA/RespB to the current ALU values, and go to DONE.
  - Capture sets RespError=0 and goes to DONE.
- DONE:
  - RespValid=1; RespA/RespB/RespZero/RespError held stable.
  - ALU outputs return to NOP.
  - On RespReady: go to IDLE.
- RespB is passed through verbatim for every op. The ALU's ResultB is meaningful only for DIV (remainder) and logic-group ops.

## Timing

- Reset: while ResetN is sampled low, the next state is IDLE. At that edge ReqReady=1 and RespValid=0. RespA=RespB=0, RespZero=1, RespError=0, Busy=0. AluInstruction=NOP, AluInputA=AluInputB=0. Counter=0.
- Reset mid-EXEC or mid-DONE aborts the operation; no response is emitted.
- All outputs are registered or decoded from state only; no combinational Req→Resp path.
- Accept at edge k:
  - ALU inputs valid from k.
  - Capture at edge k+N, where N = ADDSUB_LATENCY, LOGIC_LATENCY, or the DIV count.
  - RespValid high from edge k+N.
- NOP or error short-path: RespValid from edge k+1 after accept.
- Handshake: a response transfers on RespValid&RespReady. If RespReady is already high on the first DONE cycle, DONE lasts exactly one cycle.
- ReqReady returns one cycle after the response transfer. Minimum issue interval is N+2 cycles.
- ReqReady=0 throughout EXEC and DONE. ReqValid, ReqA and ReqB are ignored there, and changes to them do not disturb ALU inputs.
- Counter never wraps; it saturates at DIV_TIMEOUT.

## Test plan

- ADD 5+3, RespReady=1 → AluInstruction=0x01 from the accept edge; RespValid at accept+2; RespA=8, RespZero=0, RespError=0.
- DIV 100/7, ALU Ready after 10 cycles, AluReady held high beforehand from a prior DIV → stale Ready ignored for 2 cycles; RespA=14, RespB=2, RespError=0.
- DIV 100/0 → AluInstruction stays NOP; RespValid at accept+1; RespA=0xFF, RespB=100, RespError=1.
- XOR 0x5A^0x5A with RespReady low for 5 cycles → RespValid held with RespA=0x00 and RespZero=1 throughout; ReqReady=0; new ReqValid ignored; IDLE one cycle after RespReady rises.
- DIV 9/3 with AluReady stuck at 0 → RespError=1 and RespValid exactly at accept+48.
- ResetN low for one cycle during EXEC of DIV → next cycle: IDLE, ReqReady=1, RespValid=0, AluInstruction=NOP; no response ever emitted for that op.

Source files
------------

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: valid/ready front end for the SimpleALU.
// Accepts one op at a time, drives the ALU, waits a fixed latency (or the
// divider's Ready on DIV), captures the results and presents them downstream.
// Filters divide-by-zero and unknown opcodes, and bounds DIV with a timeout.
// Ports:
//   Clk, ResetN                         clock, synchronous active-low reset
//   ReqValid/ReqReady/ReqInstr/ReqA/ReqB request channel
//   AluInstruction/AluInputA/AluInputB  drive to ALU
//   AluResultA/AluResultB/AluReady      results from ALU
//   RespValid/RespReady/RespA/RespB     response channel
//   RespZero/RespError/Busy             status
module alu_issue_sequencer #(
   parameter int unsigned INPUT_BIT_WIDTH = 8,
   parameter int unsigned INSTR_BIT_WIDTH = 5,
   parameter int unsigned ADDSUB_LATENCY  = 2,
   parameter int unsigned LOGIC_LATENCY   = 1,
   parameter int unsigned DIV_MIN_CYCLES  = 2,
   parameter int unsigned DIV_TIMEOUT     = 48
) (
   input  logic                       Clk,
   input  logic                       ResetN,
   input  logic                       ReqValid,
   output logic                       ReqReady,
   input  logic [INSTR_BIT_WIDTH-1:0] ReqInstr,
   input  logic [INPUT_BIT_WIDTH-1:0] ReqA,
   input  logic [INPUT_BIT_WIDTH-1:0] ReqB,
   output logic [INSTR_BIT_WIDTH-1:0] AluInstruction,
   output logic [INPUT_BIT_WIDTH-1:0] AluInputA,
   output logic [INPUT_BIT_WIDTH-1:0] AluInputB,
   input  logic [INPUT_BIT_WIDTH-1:0] AluResultA,
   input  logic [INPUT_BIT_WIDTH-1:0] AluResultB,
   input  logic                       AluReady,
   output logic                       RespValid,
   input  logic                       RespReady,
   output logic [INPUT_BIT_WIDTH-1:0] RespA,
   output logic [INPUT_BIT_WIDTH-1:0] RespB,
   output logic                       RespZero,
   output logic                       RespError,
   output logic                       Busy
);

   localparam int unsigned W  = INPUT_BIT_WIDTH;
   localparam int unsigned IW = INSTR_BIT_WIDTH;
   // Counter range covers every latency; equals DIV_TIMEOUT when latencies are below it.
   localparam int unsigned CNT_MAX = (DIV_TIMEOUT >= ADDSUB_LATENCY && DIV_TIMEOUT >= LOGIC_LATENCY)
                                     ? DIV_TIMEOUT
                                     : ((ADDSUB_LATENCY >= LOGIC_LATENCY) ? ADDSUB_LATENCY : LOGIC_LATENCY);
   localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [IW-1:0] OP_NOP  = IW'(8'h00);
   localparam logic [IW-1:0] OP_ADD  = IW'(8'h01);
   localparam logic [IW-1:0] OP_SUB  = IW'(8'h02);
   localparam logic [IW-1:0] OP_MUL  = IW'(8'h03);
   localparam logic [IW-1:0] OP_DIV  = IW'(8'h04);
   localparam logic [IW-1:0] OP_SHL  = IW'(8'h05);
   localparam logic [IW-1:0] OP_SHR  = IW'(8'h06);
   localparam logic [IW-1:0] OP_ROL  = IW'(8'h07);
   localparam logic [IW-1:0] OP_ROR  = IW'(8'h08);
   localparam logic [IW-1:0] OP_AND  = IW'(8'h09);
   localparam logic [IW-1:0] OP_XOR  = IW'(8'h0B);
   localparam logic [IW-1:0] OP_OR   = IW'(8'h0D);
   localparam logic [IW-1:0] OP_NAND = IW'(8'h0E);
   localparam logic [IW-1:0] OP_XNOR = IW'(8'h0F);
   localparam logic [IW-1:0] OP_GTH  = IW'(8'h10);
   localparam logic [IW-1:0] OP_EQU  = IW'(8'h11);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;
   typedef enum logic [2:0] {CL_NOP, CL_ADDSUB, CL_LOGIC, CL_DIV, CL_BAD} op_class_e;

   // Opcode -> latency class.
   function automatic op_class_e classify(input logic [IW-1:0] op);
      op_class_e cl;
      case (op)
         OP_NOP:                           cl = CL_NOP;
         OP_ADD, OP_SUB:                   cl = CL_ADDSUB;
         OP_DIV:                           cl = CL_DIV;
         OP_MUL, OP_SHL, OP_SHR, OP_ROL,
         OP_ROR, OP_AND, OP_XOR, OP_OR,
         OP_NAND, OP_XNOR, OP_GTH, OP_EQU: cl = CL_LOGIC;
         default:                          cl = CL_BAD;
      endcase
      return cl;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]    alu_instr_q, alu_instr_d;
   logic [W-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [W-1:0]     resp_a_q, resp_a_d, resp_b_q, resp_b_d;
   logic             resp_err_q, resp_err_d;
   logic             resp_zero_q, req_ready_q, resp_valid_q, busy_q;
   logic             capture_c, timeout_c;

   // Capture / timeout decision for the op currently held in EXEC.
   always_comb begin
      capture_c = 1'b0;
      timeout_c = 1'b0;
      case (classify(alu_instr_q))
         CL_ADDSUB: capture_c = (cnt_q == CNT_W'(ADDSUB_LATENCY - 1));
         CL_LOGIC:  capture_c = (cnt_q == CNT_W'(LOGIC_LATENCY - 1));
         CL_DIV: begin
            // Leading cycles mask a Ready left over from a previous divide.
            capture_c = AluReady && (cnt_q >= CNT_W'(DIV_MIN_CYCLES));
            timeout_c = !capture_c && (cnt_q >= CNT_W'(DIV_TIMEOUT - 1));
         end
         default:   timeout_c = 1'b1;
      endcase
   end

   // Next-state and datapath.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_instr_d = alu_instr_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      resp_a_d    = resp_a_q;
      resp_b_d    = resp_b_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         ST_IDLE: begin
            alu_instr_d = OP_NOP;
            alu_a_d     = '0;
            alu_b_d     = '0;
            if (ReqValid) begin
               state_d = ST_DONE;
               case (classify(ReqInstr))
                  CL_NOP: begin
                     resp_a_d   = '0;
                     resp_b_d   = '0;
                     resp_err_d = 1'b0;
                  end
                  CL_BAD: begin
                     resp_a_d   = '0;
                     resp_b_d   = '0;
                     resp_err_d = 1'b1;
                  end
                  default: begin
                     if (classify(ReqInstr) == CL_DIV && ReqB == '0) begin
                        resp_a_d   = '1;
                        resp_b_d   = ReqA;
                        resp_err_d = 1'b1;
                     end else begin
                        alu_instr_d = ReqInstr;
                        alu_a_d     = ReqA;
                        alu_b_d     = ReqB;
                        cnt_d       = '0;
                        state_d     = ST_EXEC;
                     end
                  end
               endcase
            end
         end
         ST_EXEC: begin
            if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
            if (capture_c || timeout_c) begin
               resp_a_d    = AluResultA;
               resp_b_d    = AluResultB;
               resp_err_d  = timeout_c;
               alu_instr_d = OP_NOP;
               alu_a_d     = '0;
               alu_b_d     = '0;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (RespReady) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         alu_instr_q  <= OP_NOP;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         resp_a_q     <= '0;
         resp_b_q     <= '0;
         resp_err_q   <= 1'b0;
         resp_zero_q  <= 1'b1;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_instr_q  <= alu_instr_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         resp_a_q     <= resp_a_d;
         resp_b_q     <= resp_b_d;
         resp_err_q   <= resp_err_d;
         resp_zero_q  <= (resp_a_d == '0);
         req_ready_q  <= (state_d == ST_IDLE);
         resp_valid_q <= (state_d == ST_DONE);
         busy_q       <= (state_d != ST_IDLE);
      end
   end

   assign ReqReady       = req_ready_q;
   assign RespValid      = resp_valid_q;
   assign Busy           = busy_q;
   assign AluInstruction = alu_instr_q;
   assign AluInputA      = alu_a_q;
   assign AluInputB      = alu_b_q;
   assign RespA          = resp_a_q;
   assign RespB          = resp_b_q;
   assign RespZero       = resp_zero_q;
   assign RespError      = resp_err_q;

endmodule
